// File: rtl/gpio_cfg_loader.sv
// Serial pad-configuration loader: stores one control word per pad and
// shifts the whole chain out MSB first, then strobes serial_load.
module gpio_cfg_loader #(
  parameter int NO_PAD = 38,
  parameter int PAD_CTRL_BITS = 13,
  parameter logic [PAD_CTRL_BITS-1:0] PAD_CTRL_DEFAULT = 13'h1800
) (
  input  logic                     serial_clock,
  input  logic                     resetn,
  input  logic                     cfg_we,
  input  logic [5:0]               cfg_addr,
  input  logic [PAD_CTRL_BITS-1:0] cfg_wdata,
  input  logic [NO_PAD-1:0]        skip_mask,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     shift_enb,
  output logic                     serial_data_out,
  output logic                     serial_load
);

  localparam logic [5:0] LAST = 6'(NO_PAD - 1);
  localparam logic [3:0] MSB  = 4'(PAD_CTRL_BITS - 1);
  localparam logic [3:0] MSB2 = 4'(PAD_CTRL_BITS - 2);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_e;

  state_e state_q, state_d;
  logic [PAD_CTRL_BITS-1:0] mem_q [NO_PAD];
  logic [NO_PAD-1:0] mask_q, mask_d;
  logic [5:0] pad_q, pad_d, pad_m1;
  logic [3:0] bit_q, bit_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic shift_q, shift_d;
  logic sdo_q, sdo_d;
  logic load_q, load_d;
  logic [PAD_CTRL_BITS-1:0] word_d;

  assign pad_m1 = pad_q - 6'd1;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    pad_d   = pad_q;
    bit_d   = bit_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    shift_d = shift_q;
    load_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d  = 1'b0;
        shift_d = 1'b0;
        if (start) begin
          state_d = SHIFT;
          mask_d  = skip_mask;
          pad_d   = LAST;
          bit_d   = skip_mask[LAST] ? MSB2 : MSB;
          busy_d  = 1'b1;
          shift_d = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_q != 4'd0) begin
          bit_d = bit_q - 4'd1;
        end else if (pad_q == 6'd0) begin
          state_d = LOAD;
          shift_d = 1'b0;
          load_d  = 1'b1;
        end else begin
          pad_d = pad_m1;
          bit_d = mask_q[pad_m1] ? MSB2 : MSB;
        end
      end
      LOAD: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        shift_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        shift_d = 1'b0;
      end
    endcase
  end

  // Data bit is fetched from the next-state pointers so it is registered
  // alongside shift_enb.
  assign word_d = mem_q[pad_d];
  assign sdo_d  = shift_d & word_d[bit_d];

  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      mask_q  <= '0;
      pad_q   <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      shift_q <= 1'b0;
      sdo_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pad_q   <= pad_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      shift_q <= shift_d;
      sdo_q   <= sdo_d;
      load_q  <= load_d;
    end
  end

  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NO_PAD; i++) mem_q[i] <= PAD_CTRL_DEFAULT;
    end else if (cfg_we && !busy_q && cfg_addr <= LAST) begin
      mem_q[cfg_addr] <= cfg_wdata;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign shift_enb       = shift_q;
  assign serial_data_out = sdo_q;
  assign serial_load     = load_q;

endmodule

// File: tb/tb_gpio_cfg_loader.sv
// Bench for gpio_cfg_loader: bit-stream scoreboard plus a model of the
// pad shift chain, including one-bit-short pads.
module tb_gpio_cfg_loader;
  localparam int NP = 38;
  localparam int W  = 13;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic we = 1'b0;
  logic start = 1'b0;
  logic [5:0] addr = '0;
  logic [W-1:0] wdata = '0;
  logic [NP-1:0] mask = '0;
  logic busy, done, shen, sdo, sload;

  gpio_cfg_loader dut (
    .serial_clock(clk), .resetn(rstn), .cfg_we(we), .cfg_addr(addr),
    .cfg_wdata(wdata), .skip_mask(mask), .start(start), .busy(busy),
    .done(done), .shift_enb(shen), .serial_data_out(sdo),
    .serial_load(sload)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk = 0;
  logic [W-1:0] exp_mem [NP];
  logic [W-1:0] chain [NP];
  logic [NP-1:0] run_mask = '0;
  bit q [$];
  int shifts = 0;
  int loads = 0;
  int dones = 0;
  int exp_shifts = 0;
  logic prev_load = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic outb(input logic [W-1:0] c, input logic s);
    return s ? c[W-2] : c[W-1];
  endfunction

  function automatic logic [W-1:0] shf(input logic [W-1:0] c,
                                       input logic s, input logic in);
    return s ? {c[W-1], c[W-3:0], in} : {c[W-2:0], in};
  endfunction

  always @(negedge clk) begin
    if (rstn) begin
      if (shen) begin
        chk("queue_nonempty", 64'(q.size() != 0), 1);
        if (q.size() != 0) chk("bit", sdo, q.pop_front());
        shifts++;
        for (int k = NP - 1; k >= 1; k--)
          chain[k] = shf(chain[k], run_mask[k],
                         outb(chain[k-1], run_mask[k-1]));
        chain[0] = shf(chain[0], run_mask[0], sdo);
      end
      if (sload) begin
        loads++;
        chk("shift_count", shifts, exp_shifts);
        chk("load_sdo", sdo, 0);
        chk("load_shen", shen, 0);
        chk("queue_empty", q.size(), 0);
        for (int k = 0; k < NP; k++) begin
          if (run_mask[k])
            chk($sformatf("pad%0d_short", k), chain[k][W-2:0],
                exp_mem[k][W-2:0]);
          else
            chk($sformatf("pad%0d_word", k), chain[k], exp_mem[k]);
        end
      end
      if (done) begin
        dones++;
        chk("done_after_load", prev_load, 1);
        chk("done_busy", busy, 0);
      end
      prev_load = sload;
    end
  end

  task automatic reset_model();
    for (int k = 0; k < NP; k++) exp_mem[k] = 13'h1800;
  endtask

  task automatic begin_run(input logic [NP-1:0] m);
    mask = m;
    run_mask = m;
    shifts = 0;
    loads = 0;
    dones = 0;
    exp_shifts = NP * W - $countones(m);
    q.delete();
    for (int p = NP - 1; p >= 0; p--)
      for (int b = (m[p] ? W - 2 : W - 1); b >= 0; b--)
        q.push_back(exp_mem[p][b]);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("first_shift", shen, 1);
    chk("busy_on", busy, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (dones == 0 && n < 1200) begin
      @(posedge clk);
      #1 n++;
    end
    chk("done_seen", dones, 1);
    chk("one_load", loads, 1);
    @(posedge clk);
    #1 chk("done_pulse_low", done, 0);
    chk("one_done", dones, 1);
    chk("idle_shen", shen, 0);
  endtask

  task automatic wait_shifts(input int target);
    int n = 0;
    while (shifts < target && n < 1000) begin
      @(posedge clk);
      #1 n++;
    end
    chk("shift_reach", 64'(shifts >= target), 1);
  endtask

  task automatic wr(input logic [5:0] a, input logic [W-1:0] d,
                    input bit upd);
    we = 1'b1;
    addr = a;
    wdata = d;
    @(posedge clk);
    #1 we = 1'b0;
    if (upd) exp_mem[a] = d;
  endtask

  initial begin
    reset_model();
    for (int k = 0; k < NP; k++) chain[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_shen", shen, 0);
    chk("rst_sdo", sdo, 0);
    chk("rst_load", sload, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    begin_run('0);
    wait_done();

    begin_run(38'h12_1000_0000);
    wait_done();

    wr(6'd38, 13'h0000, 1'b0);
    wr(6'd63, 13'h07ff, 1'b0);
    for (int k = 0; k < NP; k++) wr(6'(k), 13'(13'h1000 + k), 1'b1);
    begin_run('0);
    wait_done();

    begin_run('0);
    wait_shifts(100);
    start = 1'b1;
    we = 1'b1;
    addr = 6'd5;
    wdata = 13'h0aaa;
    mask = '1;
    @(posedge clk);
    #1 start = 1'b0;
    we = 1'b0;
    wait_done();
    begin_run('0);
    wait_done();

    begin_run(38'h00_0000_00f0);
    wait_shifts(200);
    rstn = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_shen", shen, 0);
    chk("arst_sdo", sdo, 0);
    chk("arst_load", sload, 0);
    q.delete();
    reset_model();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("abort_no_load", loads, 0);

    begin_run('1);
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/gpio_cfg_loader.md
GPIO_CFG_LOADER -- requirements
Module: gpio_cfg_loader

Interface
REQ-001 SHALL have parameter NO_PAD, default 38, number of pad shift stages in the serial chain.
REQ-002 SHALL have parameter PAD_CTRL_BITS, default 13, control word width per pad.
REQ-003 SHALL have parameter PAD_CTRL_DEFAULT, default 13'h1800, reset value of every stored pad word.
REQ-004 serial_clock  input  1  single clock; all state updates on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 cfg_we  input  1  write strobe for the pad word store.
REQ-007 cfg_addr  input  6  pad index 0..NO_PAD-1.
REQ-008 cfg_wdata  input  PAD_CTRL_BITS  pad control word.
REQ-009 skip_mask  input  NO_PAD  bit k=1: pad k clock input has a hold violation, so its word is sent one bit short.
REQ-010 start  input  1  single-cycle request to shift the whole chain.
REQ-011 busy  output  1  high from first shift cycle through the load cycle.
REQ-012 done  output  1  one-cycle pulse on completion.
REQ-013 shift_enb  output  1  shift enable to every chain stage.
REQ-014 serial_data_out  output  1  serial data into pad 0 of the chain.
REQ-015 serial_load  output  1  one-cycle strobe latching shifted words into the pads.

Function
REQ-016 SHALL hold NO_PAD x PAD_CTRL_BITS word store; cfg_we=1 with cfg_addr<NO_PAD and busy=0 writes cfg_wdata to that entry on the same edge.
REQ-017 SHALL ignore writes with cfg_addr>=NO_PAD or while busy=1.
REQ-018 SHALL implement FSM IDLE -> SHIFT -> LOAD -> IDLE; all outputs registered.
REQ-019 IDLE: start=1 at an edge captures skip_mask, sets pad index to NO_PAD-1 and enters SHIFT; start ignored outside IDLE.
REQ-020 SHIFT: each cycle shift_enb=1 and serial_data_out = one bit of the current word, MSB first.
REQ-021 Word order SHALL be pad NO_PAD-1 first, pad 0 last, so each word lands in its own pad.
REQ-022 Pad with captured skip_mask bit=0: bits [PAD_CTRL_BITS-1:0] sent, PAD_CTRL_BITS cycles.
REQ-023 Pad with captured skip_mask bit=1: bit PAD_CTRL_BITS-1 dropped, bits [PAD_CTRL_BITS-2:0] sent, PAD_CTRL_BITS-1 cycles.
REQ-024 Total shift_enb-high cycles SHALL equal NO_PAD*PAD_CTRL_BITS - popcount(captured skip_mask), with no gap between words.
REQ-025 First shift bit SHALL appear on outputs the cycle after the edge that samples start.
REQ-026 After the last bit of pad 0: next cycle LOAD with shift_enb=0, serial_data_out=0, serial_load=1 for exactly one cycle.
REQ-027 The cycle after LOAD: IDLE, busy=0, done=1 for one cycle; start sampled in this cycle is accepted.
REQ-028 Bit counter 4 bits, pad counter 6 bits; no wrap past pad 0.
REQ-029 Changes to skip_mask or the store during SHIFT SHALL NOT affect the transfer in progress.

Reset
REQ-030 resetn=0 SHALL immediately force IDLE and busy, done, shift_enb, serial_data_out and serial_load to 0.
REQ-031 resetn=0 SHALL set every store entry to PAD_CTRL_DEFAULT and clear counters and captured mask.
REQ-032 Reset mid-SHIFT SHALL abort the transfer with no serial_load pulse; next start restarts from pad NO_PAD-1.

Verification
REQ-033 No writes, skip_mask=0, start -> shift_enb high 494 cycles, every pad stage holds 13'h1800, one serial_load, one done.
REQ-034 skip_mask=38'h12_1000_0000 (pads 28, 33, 36) -> shift_enb high 491 cycles; good pads hold 13'h1800, skipped pads show the expected one-bit-short capture.
REQ-035 Write pad k = 13'h1000+k for all k, skip_mask=0 -> after load, pad k stage holds 13'h1000+k.
REQ-036 start pulsed at cycle 100 of SHIFT and cfg write during SHIFT -> ignored; transfer length and data unchanged; store unchanged.
REQ-037 resetn low at cycle 200 of SHIFT -> outputs 0 at once, no serial_load, store back to 13'h1800; new start completes normally.
REQ-038 skip_mask all ones -> shift_enb high 456 cycles; done exactly 1 cycle after serial_load.
